// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage LEGv8 core.
// Detects load-use hazards between decode and execute and inserts exactly one
// bubble per load. Flushes the younger stages when a branch resolves taken in
// MEM, and freezes the whole pipe while data memory is not ready. A taken
// branch that arrives during a memory wait is remembered and applied on the
// cycle memory completes. Stall and flush events are counted in saturating
// performance counters.
module hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rn_D,
    input  logic [REG_W-1:0] rm_D,
    input  logic             useRm_D,
    input  logic [REG_W-1:0] rd_E,
    input  logic             memRead_E,
    input  logic             branchTaken_M,
    input  logic             memReady,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDUSE   = 2'd1,
        MEMWAIT = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    // Register index of XZR: reads of it never depend on a load.
    localparam logic [REG_W-1:0] XZR = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state_reg;
    state_t     state_next;
    logic       pend_branch_reg;
    logic       pend_branch_next;
    logic       load_use;
    logic       branch_any;
    logic [1:0] cnt_inc;                // [0] stall cycle, [1] branch flush
    logic [CNT_W-1:0] cnt_reg [2];

    // Hazard detect: load in EX writing a register that decode reads.
    always_comb begin
        load_use = memRead_E && (rd_E != XZR) &&
                   ((rd_E == rn_D) || (useRm_D && (rd_E == rm_D)));
        branch_any = branchTaken_M | pend_branch_reg;
    end

    // Mealy control: outputs and next state from current state and inputs.
    always_comb begin
        stall_F          = 1'b0;
        stall_D          = 1'b0;
        stall_E          = 1'b0;
        stall_M          = 1'b0;
        flush_D          = 1'b0;
        flush_E          = 1'b0;
        flush_M          = 1'b0;
        state_next       = RUN;
        pend_branch_next = pend_branch_reg;
        cnt_inc          = 2'b00;
        if (reset) begin
            flush_D          = 1'b1;
            flush_E          = 1'b1;
            flush_M          = 1'b1;
            pend_branch_next = 1'b0;
        end else begin
            case (state_reg)
                RUN, LDUSE, MEMWAIT: begin
                    if (!memReady) begin
                        // Memory wait dominates everything: freeze all stages.
                        stall_F    = 1'b1;
                        stall_D    = 1'b1;
                        stall_E    = 1'b1;
                        stall_M    = 1'b1;
                        cnt_inc[0] = 1'b1;
                        state_next = MEMWAIT;
                        pend_branch_next = (state_reg == MEMWAIT) ?
                                           (pend_branch_reg | branchTaken_M) :
                                           branchTaken_M;
                    end else if (branch_any) begin
                        // Decode instruction is squashed, so any load-use is moot.
                        flush_D          = 1'b1;
                        flush_E          = 1'b1;
                        flush_M          = 1'b1;
                        cnt_inc[1]       = 1'b1;
                        pend_branch_next = 1'b0;
                        state_next       = RUN;
                    end else if (load_use && (state_reg != LDUSE)) begin
                        // One bubble: hold PC and IF/ID, clear ID/EX.
                        stall_F    = 1'b1;
                        stall_D    = 1'b1;
                        flush_E    = 1'b1;
                        cnt_inc[0] = 1'b1;
                        state_next = LDUSE;
                    end else begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // State and pending-branch registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= RUN;
            pend_branch_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pend_branch_reg <= pend_branch_next;
        end
    end

    // Saturating performance counters: hold at all-ones, never wrap.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != '1)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
                end
            end
        end
    endgenerate

    assign state_o    = state_reg;
    assign stallCount = cnt_reg[0];
    assign flushCount = cnt_reg[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. Stimulus drives one cycle at a time,
// computes the expected response from the pipeline rules and queues it; a
// monitor on the falling edge pops and compares against two DUT instances
// (4-bit counters for saturation, 32-bit default counters).
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, useRm_D, memRead_E, branchTaken_M, memReady;
    logic [4:0] rn_D, rm_D, rd_E;

    logic s4_f, s4_d, s4_e, s4_m, f4_d, f4_e, f4_m;
    logic [1:0] st4;
    logic [3:0] sc4, fc4;
    logic s32_f, s32_d, s32_e, s32_m, f32_d, f32_e, f32_m;
    logic [1:0] st32;
    logic [31:0] sc32, fc32;

    hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .rn_D(rn_D), .rm_D(rm_D), .useRm_D(useRm_D),
        .rd_E(rd_E), .memRead_E(memRead_E), .branchTaken_M(branchTaken_M),
        .memReady(memReady),
        .stall_F(s4_f), .stall_D(s4_d), .stall_E(s4_e), .stall_M(s4_m),
        .flush_D(f4_d), .flush_E(f4_e), .flush_M(f4_m),
        .state_o(st4), .stallCount(sc4), .flushCount(fc4)
    );

    hazard_ctrl dut32 (
        .clk(clk), .reset(reset), .rn_D(rn_D), .rm_D(rm_D), .useRm_D(useRm_D),
        .rd_E(rd_E), .memRead_E(memRead_E), .branchTaken_M(branchTaken_M),
        .memReady(memReady),
        .stall_F(s32_f), .stall_D(s32_d), .stall_E(s32_e), .stall_M(s32_m),
        .flush_D(f32_d), .flush_E(f32_e), .flush_M(f32_m),
        .state_o(st32), .stallCount(sc32), .flushCount(fc32)
    );

    typedef struct {
        string       tag;
        logic [6:0]  ctl;     // {stall F,D,E,M, flush D,E,M}
        logic [1:0]  st;
        logic [3:0]  sc4;
        logic [3:0]  fc4;
        logic [31:0] sc32;
        logic [31:0] fc32;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: pipeline situation described by plain flags/counters.
    bit      m_waiting  = 1'b0;   // memory wait in progress
    bit      m_bubbled  = 1'b0;   // previous cycle inserted the load-use bubble
    bit      m_pend     = 1'b0;   // branch seen while waiting
    longint  m_stalls   = 0;
    longint  m_flushes  = 0;

    task automatic check(input string tag, input string what,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0h required=%0h", tag, what, act, req);
        end
    endtask

    function automatic logic [31:0] sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? 32'(mx) : 32'(v);
    endfunction

    // Drive one cycle of inputs, queue the expected response, advance model.
    task automatic step(input string tag, input bit rst, input bit rdy,
                        input bit bt, input bit mr, input logic [4:0] rd,
                        input logic [4:0] rn, input logic [4:0] rm, input bit um);
        exp_t e;
        bit   lu, br;
        @(posedge clk);
        #1;
        reset = rst; memReady = rdy; branchTaken_M = bt; memRead_E = mr;
        rd_E = rd; rn_D = rn; rm_D = rm; useRm_D = um;
        e.tag  = tag;
        e.st   = m_waiting ? 2'd2 : (m_bubbled ? 2'd1 : 2'd0);
        e.sc4  = 4'(sat(m_stalls, 4));
        e.fc4  = 4'(sat(m_flushes, 4));
        e.sc32 = sat(m_stalls, 32);
        e.fc32 = sat(m_flushes, 32);
        lu = mr && rd != 5'd31 && (rd == rn || (um && rd == rm));
        br = bt || m_pend;
        if (rst) begin
            e.ctl = 7'b0000_111;
            m_waiting = 0; m_bubbled = 0; m_pend = 0; m_stalls = 0; m_flushes = 0;
        end else if (!rdy) begin
            e.ctl = 7'b1111_000;
            m_pend = m_waiting ? (m_pend || bt) : bt;
            m_waiting = 1; m_bubbled = 0; m_stalls++;
        end else if (br) begin
            e.ctl = 7'b0000_111;
            m_waiting = 0; m_bubbled = 0; m_pend = 0; m_flushes++;
        end else if (lu && !m_bubbled) begin
            e.ctl = 7'b1100_010;
            m_waiting = 0; m_bubbled = 1; m_stalls++;
        end else begin
            e.ctl = 7'b0000_000;
            m_waiting = 0; m_bubbled = 0;
        end
        sb_q.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.tag, "ctl4",  {25'd0, s4_f, s4_d, s4_e, s4_m, f4_d, f4_e, f4_m}, {25'd0, e.ctl});
            check(e.tag, "ctl32", {25'd0, s32_f, s32_d, s32_e, s32_m, f32_d, f32_e, f32_m}, {25'd0, e.ctl});
            check(e.tag, "state", {30'd0, st4}, {30'd0, e.st});
            check(e.tag, "state32", {30'd0, st32}, {30'd0, e.st});
            check(e.tag, "stallCount4", {28'd0, sc4}, {28'd0, e.sc4});
            check(e.tag, "flushCount4", {28'd0, fc4}, {28'd0, e.fc4});
            check(e.tag, "stallCount32", sc32, e.sc32);
            check(e.tag, "flushCount32", fc32, e.fc32);
        end
    end

    initial begin
        reset = 1; memReady = 1; branchTaken_M = 0; memRead_E = 0;
        rd_E = 0; rn_D = 0; rm_D = 0; useRm_D = 0;

        // Reset for two cycles, then idle.
        step("reset", 1, 1, 0, 0, 0, 0, 0, 0);
        step("reset", 1, 1, 0, 0, 0, 0, 0, 0);
        step("idle",  0, 1, 0, 0, 0, 0, 0, 0);
        // Load-use on rn: one bubble, then masked while held.
        step("lduse_rn",   0, 1, 0, 1, 5'd2, 5'd2, 5'd7, 1);
        step("lduse_hold", 0, 1, 0, 1, 5'd2, 5'd2, 5'd7, 1);
        step("lduse_rm",   0, 1, 0, 1, 5'd4, 5'd9, 5'd4, 1);
        step("idle",       0, 1, 0, 0, 0, 0, 0, 0);
        // XZR and immediate-form cases never stall.
        step("xzr",        0, 1, 0, 1, 5'd31, 5'd31, 5'd31, 1);
        step("imm_form",   0, 1, 0, 1, 5'd2, 5'd5, 5'd2, 0);
        step("not_load",   0, 1, 0, 0, 5'd3, 5'd3, 5'd3, 1);
        // Branch wins over load-use.
        step("br_lduse",   0, 1, 1, 1, 5'd6, 5'd6, 5'd0, 0);
        // Memory wait with a branch in the second cycle, then flush on ready.
        step("memwait",    0, 0, 0, 0, 0, 0, 0, 0);
        step("memwait",    0, 0, 1, 0, 0, 0, 0, 0);
        step("memwait",    0, 0, 0, 0, 0, 0, 0, 0);
        step("memwait",    0, 0, 0, 0, 0, 0, 0, 0);
        step("wait_done",  0, 1, 0, 1, 5'd1, 5'd1, 5'd0, 0);
        step("after",      0, 1, 0, 0, 0, 0, 0, 0);
        // Long wait saturates the 4-bit stall counter; reset mid-wait drops the branch.
        for (int i = 0; i < 20; i++) step("sat_wait", 0, 0, (i == 3), 0, 0, 0, 0, 0);
        step("rst_midwait", 1, 0, 1, 0, 0, 0, 0, 0);
        step("post_rst",    0, 1, 0, 0, 0, 0, 0, 0);
        step("post_rst",    0, 1, 0, 0, 0, 0, 0, 0);
        // Wait then resume directly into a load-use.
        step("wait_lu",     0, 0, 0, 1, 5'd8, 5'd8, 0, 0);
        step("resume_lu",   0, 1, 0, 1, 5'd8, 5'd8, 0, 0);
        step("lu_masked",   0, 1, 0, 1, 5'd8, 5'd8, 0, 0);

        // Randomized traffic over a small register set to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            logic [4:0] pick [5];
            pick[0] = 5'd0; pick[1] = 5'd1; pick[2] = 5'd2; pick[3] = 5'd3; pick[4] = 5'd31;
            step("rand", ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 1) == 1,
                 pick[$urandom_range(0, 4)], pick[$urandom_range(0, 4)],
                 pick[$urandom_range(0, 4)], $urandom_range(0, 1) == 1);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
